// File: rtl/fetch_buffer_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Requests use valid/ready; responses return in order, one word per rvalid.
interface fetch_buffer_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_buffer_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem
// requests, buffers returned words and drives the F/D pipeline register.
// DEPTH bounds outstanding requests plus queued words (legal range 1..4).
module fetch_buffer_unit #(
   parameter int unsigned DEPTH        = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        StallF,
   input  logic                        StallD,
   input  logic                        FlushD,
   input  logic                        PCSrcW,
   input  logic [31:0]                 ResultW,
   fetch_buffer_unit_if.master         imem,
   output logic [31:0]                 PCF,
   output logic [31:0]                 InstrD,
   output logic [31:0]                 PCD,
   output logic                        ValidD
);

   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [2:0]    CAP      = 3'(DEPTH);

   logic [31:0]   fpc;
   logic [31:0]   dpc;
   logic [2:0]    out_cnt;
   logic [2:0]    q_cnt;
   logic [2:0]    drop_cnt;
   logic [31:0]   q_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   instr_d;
   logic [31:0]   pc_d;
   logic          valid_d;

   logic          issue_ok;
   logic          req;
   logic          accept;
   logic          resp_v;
   logic          resp_keep;
   logic          dec_adv;
   logic          pop;
   logic          bypass;
   logic          push;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   // Issue gating, response qualification and decode-side push/pop decisions.
   // A response with no outstanding request is stale and ignored; a response
   // in a redirect cycle or while drops are pending never reaches the queue.
   always_comb begin
      issue_ok  = ({1'b0, out_cnt} + {1'b0, q_cnt}) < {1'b0, CAP};
      req       = reset && !StallF && !PCSrcW && issue_ok;
      accept    = req && imem.imem_ready;
      resp_v    = imem.imem_rvalid && (out_cnt != '0);
      resp_keep = resp_v && !PCSrcW && (drop_cnt == '0);
      dec_adv   = !PCSrcW && !StallD && !FlushD;
      pop       = dec_adv && (q_cnt != '0);
      bypass    = dec_adv && (q_cnt == '0) && resp_keep;
      push      = resp_keep && !bypass;
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = fpc;
   assign PCF            = fpc;
   assign InstrD         = instr_d;
   assign PCD            = pc_d;
   assign ValidD         = valid_d;

   // Fetch PC, outstanding-request count and pending-drop count.
   // On redirect every request still outstanding after this edge is marked
   // for discard; that already covers any drops pending from earlier.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc      <= RESET_VECTOR;
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt <= out_cnt + 3'(accept) - 3'(resp_v);
         if (PCSrcW) begin
            fpc      <= ResultW;
            drop_cnt <= out_cnt - 3'(resp_v);
         end else begin
            if (accept) begin
               fpc <= fpc + 32'd4;
            end
            if (resp_v && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - 3'd1;
            end
         end
      end
   end

   // Word queue plus the PC of the oldest undelivered word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         q_cnt  <= '0;
         dpc    <= RESET_VECTOR;
      end else if (PCSrcW) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         q_cnt  <= '0;
         dpc    <= ResultW;
      end else begin
         if (push) begin
            q_mem[wr_ptr] <= imem.imem_rdata;
            wr_ptr        <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         q_cnt <= q_cnt + 3'(push) - 3'(pop);
         if (pop || bypass) begin
            dpc <= dpc + 32'd4;
         end
      end
   end

   // F/D pipeline register: redirect beats stall beats flush beats delivery.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_d <= '0;
         pc_d    <= RESET_VECTOR;
         valid_d <= 1'b0;
      end else if (PCSrcW) begin
         valid_d <= 1'b0;
      end else if (!StallD) begin
         if (FlushD) begin
            valid_d <= 1'b0;
         end else if (pop) begin
            instr_d <= q_mem[rd_ptr];
            pc_d    <= dpc;
            valid_d <= 1'b1;
         end else if (bypass) begin
            instr_d <= imem.imem_rdata;
            pc_d    <= dpc;
            valid_d <= 1'b1;
         end else begin
            valid_d <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Randomized bench for fetch_buffer_unit against a transaction-level model:
// outstanding requests and undelivered words are kept as queues of
// {address, data} records and decode takes the oldest buffered word.
module tb_fetch_buffer_unit;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] PAT   = 32'hA5A5_0000;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } word_t;

   logic        clk;
   logic        reset;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        pcsrc_w;
   logic [31:0] result_w;
   logic [31:0] pcf;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        valid_d;

   fetch_buffer_unit_if imem_bus ();

   fetch_buffer_unit #(
      .DEPTH        (DEPTH),
      .RESET_VECTOR (RV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .StallF  (stall_f),
      .StallD  (stall_d),
      .FlushD  (flush_d),
      .PCSrcW  (pcsrc_w),
      .ResultW (result_w),
      .imem    (imem_bus.master),
      .PCF     (pcf),
      .InstrD  (instr_d),
      .PCD     (pc_d),
      .ValidD  (valid_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   req_t        pend [$];
   word_t       wq [$];
   logic [31:0] m_fpc;
   logic [31:0] m_pcd;
   logic [31:0] m_instr;
   bit          m_valid;
   bit          exp_req;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit pct(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic model_reset();
      pend.delete();
      wq.delete();
      m_fpc   = RV;
      m_pcd   = RV;
      m_instr = '0;
      m_valid = 1'b0;
   endtask

   task automatic check_outputs();
      exp_req = reset && !stall_f && !pcsrc_w && ((pend.size() + wq.size()) < int'(DEPTH));
      check_eq("imem_req",  32'(imem_bus.imem_req), 32'(exp_req));
      check_eq("imem_addr", imem_bus.imem_addr,     m_fpc);
      check_eq("PCF",       pcf,                    m_fpc);
      check_eq("ValidD",    32'(valid_d),           32'(m_valid));
      check_eq("PCD",       pc_d,                   m_pcd);
      check_eq("InstrD",    instr_d,                m_instr);
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      req_t  r;
      req_t  nr;
      word_t w;
      bit    keep;
      bit    accept;
      accept = exp_req && imem_bus.imem_ready;
      keep   = 1'b0;
      w.pc   = '0;
      w.data = '0;
      if (imem_bus.imem_rvalid && pend.size() != 0) begin
         r      = pend.pop_front();
         keep   = !r.stale && !pcsrc_w;
         w.pc   = r.addr;
         w.data = imem_bus.imem_rdata;
      end
      if (pcsrc_w) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         wq.delete();
         m_valid = 1'b0;
         m_fpc   = result_w;
      end else begin
         if (accept) begin
            nr.addr  = m_fpc;
            nr.stale = 1'b0;
            pend.push_back(nr);
            m_fpc = m_fpc + 32'd4;
         end
         if (stall_d) begin
            if (keep) wq.push_back(w);
         end else if (flush_d) begin
            m_valid = 1'b0;
            if (keep) wq.push_back(w);
         end else begin
            if (keep) wq.push_back(w);
            if (wq.size() != 0) begin
               w       = wq.pop_front();
               m_valid = 1'b1;
               m_pcd   = w.pc;
               m_instr = w.data;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0100;
         1:       return 32'hFFFF_FFF8;
         2:       return 32'h0000_0040;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   // Percent knobs: ready, in-order response, stray rvalid, StallF, StallD,
   // FlushD, redirect.
   task automatic run_cycles(input int n, input int p_rdy, input int p_rv, input int p_stray,
                             input int p_sf, input int p_sd, input int p_fl, input int p_rd);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         stall_f  = pct(p_sf);
         stall_d  = pct(p_sd);
         flush_d  = pct(p_fl);
         pcsrc_w  = pct(p_rd);
         result_w = pick_target();
         imem_bus.imem_ready = pct(p_rdy);
         if (pend.size() != 0 && pct(p_rv)) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = pend[0].addr ^ PAT;
         end else if (pend.size() == 0 && pct(p_stray)) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = $urandom;
         end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = $urandom;
         end
         #1;
         check_outputs();
         model_step();
      end
   endtask

   task automatic idle_inputs();
      stall_f              = 1'b0;
      stall_d              = 1'b0;
      flush_d              = 1'b0;
      pcsrc_w              = 1'b0;
      result_w             = '0;
      imem_bus.imem_ready  = 1'b0;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
   endtask

   // Release reset with a stray response present on the first edge.
   task automatic release_cycle();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      imem_bus.imem_ready  = 1'b1;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'hDEAD_BEEF;
      #1;
      check_outputs();
      model_step();
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      idle_inputs();
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(negedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      #1;
      reset = 1'b0;
      #2;
      check_outputs();
      repeat (2) @(negedge clk);
      release_cycle();

      // zero-wait stream
      run_cycles(12, 100, 100, 0, 0, 0, 0, 0);
      // decode stall held for three cycles, then resume
      run_cycles(3, 100, 100, 0, 0, 100, 0, 0);
      run_cycles(6, 100, 100, 0, 0, 0, 0, 0);
      // build up outstanding requests, redirect, drain the dropped responses
      run_cycles(3, 100, 0, 0, 0, 0, 0, 0);
      run_cycles(1, 0, 0, 0, 0, 0, 0, 100);
      run_cycles(8, 100, 100, 0, 0, 0, 0, 0);
      // memory not ready for four cycles
      run_cycles(4, 0, 100, 0, 0, 0, 0, 0);
      run_cycles(4, 100, 100, 0, 0, 0, 0, 0);
      // queue one word under stall, then flush
      run_cycles(2, 100, 100, 0, 0, 100, 0, 0);
      run_cycles(1, 0, 0, 0, 100, 0, 100, 0);
      run_cycles(4, 100, 100, 0, 0, 0, 0, 0);

      // randomized mixes
      run_cycles(300, 40, 60, 10, 10, 20, 15, 5);
      run_cycles(200, 100, 30, 10, 0, 10, 5, 15);
      run_cycles(300, 70, 70, 5, 15, 25, 10, 8);

      // reset with requests outstanding
      run_cycles(3, 100, 0, 0, 0, 0, 0, 0);
      async_reset();
      release_cycle();
      run_cycles(12, 100, 100, 0, 0, 0, 0, 0);
      run_cycles(400, 60, 60, 10, 10, 20, 10, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
